alu_operand_sequencer: RTL and testbench

- Upstream control stage for the 8-bit ALU: accepts 16-bit instruction words over a valid/ready handshake and holds a 4-entry x 8-bit register file.
- Drives registered operands A/B, the 5-bit select and CarryIn into the ALU, waits for the ALU's registered result, then writes it back to the register file.
- Keeps a carry flag so multi-byte add chains can be built from successive AddC operations.

---
 rtl/alu_operand_sequencer.sv | 164 ++++++++++++++++
 tb/tb_alu_operand_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_sequencer.sv
// Sequencer that feeds register-file operands to an external 8-bit ALU and writes its result back.
// Define SEQ_ZERO_FLAG_EN to add a zero_flag output refreshed on every writeback.
module alu_operand_sequencer #(
    parameter int DATA_W  = 8,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        alu_sel,
    output logic              alu_cin,
    input  logic [DATA_W-1:0] alu_y,
    output logic              done,
    output logic [DATA_W-1:0] result,
`ifdef SEQ_ZERO_FLAG_EN
    output logic              carry_flag,
    output logic              zero_flag
`else
    output logic              carry_flag
`endif
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] rf_q [4];
    logic [DATA_W-1:0] rf_d [4];
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [4:0]        alu_sel_q, alu_sel_d;
    logic              alu_cin_q, alu_cin_d;
    logic [1:0]        dst_q, dst_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              carry_q, carry_d;
`ifdef SEQ_ZERO_FLAG_EN
    logic              zero_q, zero_d;
`endif

    logic              is_load, use_carry, op_cin, sum_cin, is_add_op;
    logic [4:0]        sel;
    logic [1:0]        dst, ra, rb;
    logic [DATA_W-1:0] imm;
    logic [DATA_W:0]   sum_ab;
    logic              unused_bits;

    assign is_load     = in_instr[15];
    assign sel         = in_instr[14:10];
    assign dst         = in_instr[9:8];
    assign ra          = in_instr[7:6];
    assign rb          = in_instr[5:4];
    assign use_carry   = in_instr[0];
    assign imm         = DATA_W'(in_instr[7:0]);
    assign unused_bits = ^in_instr[3:1];

    // Carry is produced here from pre-update register contents; only AddC folds in the old flag.
    assign op_cin    = use_carry ? carry_q : 1'b0;
    assign is_add_op = sel[2] && (sel[1:0] == 2'b01 || sel[1:0] == 2'b10);
    assign sum_cin   = (sel[1:0] == 2'b01) ? op_cin : 1'b0;
    assign sum_ab    = {1'b0, rf_q[ra]} + {1'b0, rf_q[rb]} + {{DATA_W{1'b0}}, sum_cin};

    always_comb begin
        state_d   = state_q;
        rf_d      = rf_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        alu_cin_d = alu_cin_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        result_d  = result_q;
        carry_d   = carry_q;
`ifdef SEQ_ZERO_FLAG_EN
        zero_d    = zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (is_load) begin
                        rf_d[dst] = imm;
                    end else begin
                        alu_a_d   = rf_q[ra];
                        alu_b_d   = rf_q[rb];
                        alu_sel_d = sel;
                        alu_cin_d = op_cin;
                        dst_d     = dst;
                        if (is_add_op) carry_d = sum_ab[DATA_W];
                        state_d   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = 3'(ALU_LAT - 1);
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) state_d = WB;
                else               cnt_d   = cnt_q - 3'd1;
            end
            WB: begin
                rf_d[dst_q] = alu_y;
                result_d    = alu_y;
                done_d      = 1'b1;
`ifdef SEQ_ZERO_FLAG_EN
                zero_d      = (alu_y == '0);
`endif
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < 4; i++) rf_q[i] <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= '0;
            alu_cin_q <= 1'b0;
            dst_q     <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
`ifdef SEQ_ZERO_FLAG_EN
            zero_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rf_q      <= rf_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            alu_cin_q <= alu_cin_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
`ifdef SEQ_ZERO_FLAG_EN
            zero_q    <= zero_d;
`endif
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_sel    = alu_sel_q;
    assign alu_cin    = alu_cin_q;
    assign done       = done_q;
    assign result     = result_q;
    assign carry_flag = carry_q;
`ifdef SEQ_ZERO_FLAG_EN
    assign zero_flag  = zero_q;
`endif

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed scenarios followed by random instructions,
// checked against an instruction-level model of the register file and carry flag.
module tb_alu_operand_sequencer;

    localparam int ALU_LAT = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [7:0]  alu_a, alu_b, alu_y, result;
    logic [4:0]  alu_sel;
    logic        alu_cin, done, carry_flag;
`ifdef SEQ_ZERO_FLAG_EN
    logic        zero_flag;
`endif

    int checks   = 0;
    int failures = 0;

    // Instruction-level reference state
    logic [7:0] m_rf [4];
    logic       m_carry;
    logic       m_zero;

    alu_operand_sequencer #(.DATA_W(8), .ALU_LAT(ALU_LAT)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sel    (alu_sel),
        .alu_cin    (alu_cin),
        .alu_y      (alu_y),
        .done       (done),
        .result     (result),
`ifdef SEQ_ZERO_FLAG_EN
        .carry_flag (carry_flag),
        .zero_flag  (zero_flag)
`else
        .carry_flag (carry_flag)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural ALU used both as the DUT's environment and to predict write-back values
    function automatic logic [7:0] aluFn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [4:0] sel, input logic cin);
        case (sel[2:0])
            3'b110:  return a + b;
            3'b101:  return a + b + {7'b0, cin};
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~a;
            3'b100:  return a - b;
            default: return b;
        endcase
    endfunction

    // ALU with ALU_LAT cycles of registered latency from sampling to Y
    logic [7:0] alu_pipe [ALU_LAT];
    always @(posedge clk) begin
        alu_pipe[0] <= aluFn(alu_a, alu_b, alu_sel, alu_cin);
        for (int i = 1; i < ALU_LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
    end
    assign alu_y = alu_pipe[ALU_LAT-1];

    function automatic logic [15:0] mkOp(input logic [4:0] sel, input logic [1:0] dst,
                                         input logic [1:0] ra, input logic [1:0] rb, input logic uc);
        return {1'b0, sel, dst, ra, rb, 3'b000, uc};
    endfunction

    function automatic logic [15:0] mkLd(input logic [1:0] dst, input logic [7:0] imm);
        return {1'b1, 5'b0, dst, imm};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction from a negedge with the DUT idle; returns at the negedge after
    // the accept (load) or in the done cycle (ALU op). With hold set, in_valid stays high
    // carrying nxt while the DUT is busy, and the caller must issue nxt next.
    task automatic applyStimulus(input logic [15:0] instr, input logic [15:0] nxt, input bit hold);
        logic [7:0]  a, b, y;
        logic [4:0]  sel;
        logic [1:0]  dst, ra, rb;
        logic        cin;
        logic [21:0] exp_alu;
        int          s;
        in_valid = 1'b1;
        in_instr = instr;
        checkOutput("ready_before_accept", in_ready, 1);
        @(negedge clk);
        if (hold) in_instr = nxt;
        else      in_valid = 1'b0;
        if (instr[15]) begin
            m_rf[instr[9:8]] = instr[7:0];
            checkOutput("load_flags", {in_ready, done}, 2'b10);
            return;
        end
        sel = instr[14:10]; dst = instr[9:8]; ra = instr[7:6]; rb = instr[5:4];
        a   = m_rf[ra];
        b   = m_rf[rb];
        cin = instr[0] ? m_carry : 1'b0;
        exp_alu = {a, b, sel, cin};
        s = int'(a) + int'(b) + ((sel[1:0] == 2'b01) ? int'(cin) : 0);
        if (sel[2] && (sel[1:0] == 2'b01 || sel[1:0] == 2'b10)) m_carry = (s > 255);
        y = aluFn(a, b, sel, cin);
        checkOutput("issue_alu", {alu_a, alu_b, alu_sel, alu_cin}, exp_alu);
        checkOutput("issue_carry", carry_flag, m_carry);
        checkOutput("issue_flags", {in_ready, done}, 2'b00);
        for (int k = 0; k < ALU_LAT + 1; k++) begin
            @(negedge clk);
            checkOutput("busy_alu", {alu_a, alu_b, alu_sel, alu_cin}, exp_alu);
            checkOutput("busy_flags", {in_ready, done}, 2'b00);
        end
        @(negedge clk);
        m_rf[dst] = y;
        m_zero    = (y == 8'h00);
        checkOutput("wb_flags", {in_ready, done}, 2'b11);
        checkOutput("wb_result", result, y);
        checkOutput("wb_carry", carry_flag, m_carry);
`ifdef SEQ_ZERO_FLAG_EN
        checkOutput("wb_zero", zero_flag, m_zero);
`endif
    endtask

    // Drop the model back to its reset state
    task automatic modelReset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_carry = 1'b0;
        m_zero  = 1'b0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_flags"}, {in_ready, done}, 2'b10);
        checkOutput({tag, "_alu"}, {alu_a, alu_b, alu_sel, alu_cin}, 0);
        checkOutput({tag, "_result"}, {result, carry_flag}, 0);
`ifdef SEQ_ZERO_FLAG_EN
        checkOutput({tag, "_zero"}, zero_flag, 0);
`endif
    endtask

    // Watchdog so the run can never hang
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios, then random traffic
    initial begin
        logic [15:0] cur, nxt;
        bit          hold;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkResetState("reset");

        $display("[TB] loads then Add");
        applyStimulus(mkLd(2'd0, 8'h12), 16'h0, 1'b0);
        applyStimulus(mkLd(2'd1, 8'h34), 16'h0, 1'b0);
        applyStimulus(mkOp(5'b00110, 2'd2, 2'd0, 2'd1, 1'b0), 16'h0, 1'b0);
        applyStimulus(mkOp(5'b00000, 2'd3, 2'd2, 2'd2, 1'b0), 16'h0, 1'b0);

        $display("[TB] carry chain");
        applyStimulus(mkLd(2'd0, 8'hFF), 16'h0, 1'b0);
        applyStimulus(mkLd(2'd1, 8'h01), 16'h0, 1'b0);
        applyStimulus(mkOp(5'b00110, 2'd2, 2'd0, 2'd1, 1'b0), 16'h0, 1'b0);
        applyStimulus(mkLd(2'd3, 8'h00), 16'h0, 1'b0);
        applyStimulus(mkOp(5'b00101, 2'd3, 2'd3, 2'd3, 1'b1), 16'h0, 1'b0);

        $display("[TB] backpressure");
        applyStimulus(mkOp(5'b00110, 2'd1, 2'd0, 2'd1, 1'b0),
                      mkOp(5'b00010, 2'd0, 2'd0, 2'd1, 1'b0), 1'b1);
        applyStimulus(mkOp(5'b00010, 2'd0, 2'd0, 2'd1, 1'b0), 16'h0, 1'b0);
        applyStimulus(mkOp(5'b00111, 2'd2, 2'd3, 2'd0, 1'b0), 16'h0, 1'b0);

        $display("[TB] reset mid-operation");
        in_valid = 1'b1;
        in_instr = mkOp(5'b00110, 2'd0, 2'd0, 2'd1, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelReset();
        checkResetState("midreset");
        for (int k = 0; k < ALU_LAT + 3; k++) begin
            @(negedge clk);
            checkOutput("midreset_idle", {in_ready, done}, 2'b10);
        end
        applyStimulus(mkOp(5'b00111, 2'd0, 2'd0, 2'd1, 1'b0), 16'h0, 1'b0);
        applyStimulus(mkOp(5'b00111, 2'd0, 2'd2, 2'd3, 1'b0), 16'h0, 1'b0);

        $display("[TB] random traffic");
        cur = 16'($urandom);
        for (int i = 0; i < 80; i++) begin
            nxt  = 16'($urandom);
            hold = (i < 79) && ($urandom_range(0, 1) == 1);
            applyStimulus(cur, nxt, hold);
            cur = nxt;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("final_idle", {in_ready, done}, 2'b10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
